mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/data) to single memory master arbiter with stall watchdog.
// Ports: clk, reset (async, active-high); i_* fetch port (read-only);
//   d_* data port; m_* memory master; grant (00 none/01 fetch/10 data);
//   bus_error (sticky watchdog flag).
// Optional: define ARB_ROUND_ROBIN_EN for round-robin contention handling;
//   otherwise the data port always wins.
module mem_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic [1:0]  grant,
    output logic        bus_error
);

    localparam logic [15:0] LP_MAX_WAIT = 16'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait_cnt;
    logic        r_bus_error;
    logic        w_d_req;
    logic        w_pick_d;
    logic        w_watchdog;

    assign w_d_req    = d_read | d_write;
    assign w_watchdog = (r_state != IDLE) && (r_wait_cnt == LP_MAX_WAIT);

`ifdef ARB_ROUND_ROBIN_EN
    // 1: data port was served last, so fetch wins the next contention
    logic r_last_d;
    logic w_leave;

    assign w_leave  = (r_state != IDLE) && (w_next == IDLE);
    assign w_pick_d = w_d_req && (!i_read || !r_last_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if (w_leave) begin
            r_last_d <= (r_state == GRANT_D);
        end
    end
`else
    assign w_pick_d = w_d_req;
`endif

    always_comb begin
        w_next        = r_state;
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        i_readdata    = '0;
        d_readdata    = '0;
        // a requesting port stalls until it is granted
        i_waitrequest = i_read;
        d_waitrequest = w_d_req;
        unique case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_next = GRANT_D;
                end else if (i_read) begin
                    w_next = GRANT_I;
                end
            end
            GRANT_I: begin
                m_address     = i_address;
                m_byteenable  = 4'hF;
                i_waitrequest = m_waitrequest;
                i_readdata    = m_readdata;
                if (w_watchdog) begin
                    // release the port with a null response
                    i_waitrequest = 1'b0;
                    i_readdata    = '0;
                    w_next        = IDLE;
                end else begin
                    m_read = i_read;
                    if (!i_read || !m_waitrequest) begin
                        w_next = IDLE;
                    end
                end
            end
            GRANT_D: begin
                m_address     = d_address;
                m_writedata   = d_writedata;
                m_byteenable  = d_byteenable;
                d_waitrequest = m_waitrequest;
                d_readdata    = m_readdata;
                if (w_watchdog) begin
                    d_waitrequest = 1'b0;
                    d_readdata    = '0;
                    w_next        = IDLE;
                end else begin
                    // simultaneous read+write resolves to a write
                    m_write = d_write;
                    m_read  = d_read & ~d_write;
                    if (!w_d_req || !m_waitrequest) begin
                        w_next = IDLE;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // cleared while idle, so every grant starts counting from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_wait_cnt <= '0;
        end else if (m_waitrequest) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_error <= 1'b0;
        end else if (w_watchdog) begin
            r_bus_error <= 1'b1;
        end
    end

    assign grant     = r_state;
    assign bus_error = r_bus_error;

endmodule
